sram_array_bram: RTL and testbench

//  Generic single-port SRAM array for the FPGA build, replacing per-array fixed-size BRAM IP wrappers.

---
 rtl/sram_array_pkg.sv | 31 +++
 rtl/sram_array_core.sv | 33 +++
 rtl/sram_array_bram.sv | 135 +++++++++++++
 tb/tb_sram_array_bram.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/sram_array_pkg.sv
// Shared types and helpers for the single-port SRAM array (sram_array_bram and its RAM core).
// State encoding, a constant-evaluable clog2, and a segment-mask to bit-enable expander.
package sram_array_pkg;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  localparam int MAX_DATA_W = 4096;
  localparam int MAX_MASK_W = 1024;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

  // Bit b of the result follows the mask bit of the segment that contains b.
  function automatic logic [MAX_DATA_W-1:0] expand_mask(input logic [MAX_MASK_W-1:0] mask,
                                                        input int data_w, input int mask_w);
    logic [MAX_DATA_W-1:0] bits;
    bits = '0;
    for (int b = 0; b < MAX_DATA_W; b++) begin
      if (b < data_w) bits[b] = mask[b / (data_w / mask_w)];
    end
    return bits;
  endfunction

endpackage

// File: rtl/sram_array_core.sv
// Inferred block RAM with per-segment write enables and a registered read port.
// No reset on purpose so the synthesiser maps it straight onto BRAM primitives.
module sram_array_core #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 256,
  parameter int MASK_W = 4
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  input  logic              re,
  input  logic [MASK_W-1:0] we,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  import sram_array_pkg::*;

  localparam int DEPTH = 1 << ADDR_W;
  localparam int SEG_W = DATA_W / MASK_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    for (int i = 0; i < MASK_W; i++) begin
      if (we[i]) mem_q[addr][i*SEG_W +: SEG_W] <= wdata[i*SEG_W +: SEG_W];
    end
    // Read port only moves on a real read, so the output holds between reads.
    if (re) rdata_q <= mem_q[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/sram_array_bram.sv
// Single-port SRAM array: post-reset clear sweep, masked writes, read-valid strobe.
// Define SRAM_OUTREG_EN to add an output register stage (read latency 2 instead of 1).
module sram_array_bram
  import sram_array_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 256,
  parameter int MASK_W  = 4,
  parameter int CLR_VAL = 0
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] RW0_addr,
  input  logic              RW0_en,
  input  logic              RW0_wmode,
  input  logic [DATA_W-1:0] RW0_wdata,
  input  logic [MASK_W-1:0] RW0_wmask,
  output logic [DATA_W-1:0] RW0_rdata,
  output logic              RW0_rvalid,
  output logic              init_done,
  output state_t            dbg_state
);

  if (DATA_W % MASK_W != 0) begin : g_bad_mask
    $error("sram_array_bram: DATA_W must be a multiple of MASK_W");
  end
  if (CLR_VAL != 0 && CLR_VAL != 1) begin : g_bad_clr
    $error("sram_array_bram: CLR_VAL must be 0 or 1");
  end

  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};
  localparam logic [DATA_W-1:0] CLR_WORD  = (CLR_VAL != 0) ? {DATA_W{1'b1}} : {DATA_W{1'b0}};

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
  logic              is_clear;
  logic              read_req;
  logic [ADDR_W-1:0] ram_addr;
  logic [MASK_W-1:0] ram_we;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  assign is_clear = (state_q == ST_CLEAR);

  // Sweep ends on the last address; READY never re-enters CLEAR, so the wrap is harmless.
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    if (is_clear) begin
      clr_addr_d = clr_addr_q + 1'b1;
      if (clr_addr_q == LAST_ADDR) state_d = ST_READY;
    end
  end

  always_comb begin
    ram_addr  = RW0_addr;
    ram_we    = '0;
    ram_wdata = RW0_wdata;
    read_req  = 1'b0;
    if (reset_n) begin
      if (is_clear) begin
        ram_addr  = clr_addr_q;
        ram_we    = '1;
        ram_wdata = CLR_WORD;
      end else if (RW0_en) begin
        if (RW0_wmode) ram_we = RW0_wmask;
        else           read_req = 1'b1;
      end
    end
  end

  sram_array_core #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .MASK_W (MASK_W)
  ) u_core (
    .clk   (clock),
    .addr  (ram_addr),
    .re    (read_req),
    .we    (ram_we),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q    <= ST_CLEAR;
      clr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  assign init_done = (state_q == ST_READY);
  assign dbg_state = state_q;

`ifdef SRAM_OUTREG_EN
  logic              rv1_q, rv2_q;
  logic [DATA_W-1:0] out_q;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rv1_q <= 1'b0;
      rv2_q <= 1'b0;
      out_q <= '0;
    end else begin
      rv1_q <= read_req;
      rv2_q <= rv1_q;
      if (rv1_q) out_q <= ram_rdata;
    end
  end

  assign RW0_rdata  = out_q;
  assign RW0_rvalid = rv2_q;
`else
  logic rv1_q;
  logic seen_q;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rv1_q  <= 1'b0;
      seen_q <= 1'b0;
    end else begin
      rv1_q  <= read_req;
      seen_q <= seen_q | read_req;
    end
  end

  // The RAM register has no reset; report zero until the first read since reset lands.
  assign RW0_rdata  = seen_q ? ram_rdata : '0;
  assign RW0_rvalid = rv1_q;
`endif

endmodule

// File: tb/tb_sram_array_bram.sv
// Directed plus random bench for sram_array_bram (ADDR_W=4, DATA_W=256, MASK_W=32).
// Honours SRAM_OUTREG_EN for the expected read latency.
module tb_sram_array_bram;
  import sram_array_pkg::*;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 256;
  localparam int MASK_W = 32;
  localparam int DEPTH  = 16;
  localparam int SEG_W  = DATA_W / MASK_W;
`ifdef SRAM_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic [ADDR_W-1:0] addr = '0;
  logic              en = 1'b0;
  logic              wmode = 1'b0;
  logic [DATA_W-1:0] wdata = '0;
  logic [MASK_W-1:0] wmask = '0;
  logic [DATA_W-1:0] rdata;
  logic              rvalid;
  logic              init_done;
  state_t            dbg_state;

  logic [DATA_W-1:0] model [DEPTH];
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] last_exp = '0;
  logic              rd_issue = 1'b0;
  logic [1:0]        vpipe = '0;
  logic              rst_q = 1'b1;
  logic              mon_en = 1'b0;
  int                checks = 0;
  int                errors = 0;

  sram_array_bram #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .MASK_W  (MASK_W),
    .CLR_VAL (0)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .RW0_addr   (addr),
    .RW0_en     (en),
    .RW0_wmode  (wmode),
    .RW0_wdata  (wdata),
    .RW0_wmask  (wmask),
    .RW0_rdata  (rdata),
    .RW0_rvalid (rvalid),
    .init_done  (init_done),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [DATA_W-1:0] rand_word();
    logic [DATA_W-1:0] r;
    for (int i = 0; i < DATA_W / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // driver: inputs change 1 time unit after a rising edge, sampled at the next one
  task automatic op(input logic e, input logic w, input logic [ADDR_W-1:0] a,
                    input logic [DATA_W-1:0] d, input logic [MASK_W-1:0] m, input logic live);
    @(posedge clock);
    #1;
    en = e; wmode = w; addr = a; wdata = d; wmask = m;
    rd_issue = live && e && !w;
    if (live && e && w) begin
      for (int i = 0; i < MASK_W; i++)
        if (m[i]) model[a][i*SEG_W +: SEG_W] = d[i*SEG_W +: SEG_W];
    end
    if (rd_issue) exp_q.push_back(model[a]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) op(1'b0, 1'b0, '0, '0, '0, 1'b0);
  endtask

  task automatic sweep_check(input string tag);
    for (int k = 1; k <= DEPTH; k++) begin
      op(k < DEPTH, 1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, DEPTH-1)),
         rand_word(), '1, 1'b0);
      chk(tag, DATA_W'(init_done), DATA_W'(k == DEPTH));
    end
  endtask

  task automatic read_all();
    for (int a = 0; a < DEPTH; a++) op(1'b1, 1'b0, ADDR_W'(a), '0, '0, 1'b1);
    idle(LAT + 2);
  endtask

  // expected rvalid timeline from the issued reads
  always @(posedge clock) begin
    rst_q <= !reset_n;
    if (!reset_n) vpipe <= '0;
    else          vpipe <= {vpipe[0], rd_issue};
  end

  // scoreboard
  always @(negedge clock) begin
    if (mon_en) begin
      if (rst_q) last_exp = '0;
      chk("rvalid", DATA_W'(rvalid), DATA_W'(vpipe[LAT-1]));
      if (rvalid === 1'b1) begin
        chk("rd_has_expect", DATA_W'(exp_q.size() != 0), DATA_W'(1));
        if (exp_q.size() != 0) begin
          last_exp = exp_q.pop_front();
          chk("rdata", rdata, last_exp);
        end
      end else begin
        chk("rdata_hold", rdata, last_exp);
      end
    end
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) model[i] = '0;

    // reset state
    repeat (3) @(posedge clock);
    #1;
    mon_en = 1'b1;
    chk("init_done_rst", DATA_W'(init_done), '0);
    chk("state_rst", DATA_W'(dbg_state), DATA_W'(ST_CLEAR));

    // release; junk requests during the sweep must be ignored
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    en = 1'b1; wmode = 1'b1; addr = 4'd3; wdata = '1; wmask = '1;
    sweep_check("init_done_sweep");
    chk("state_ready", DATA_W'(dbg_state), DATA_W'(ST_READY));
    read_all();

    // masked writes to address 5
    op(1'b1, 1'b1, 4'd5, {32{8'hAA}}, '1, 1'b1);
    op(1'b1, 1'b1, 4'd5, {32{8'h55}}, 32'h2, 1'b1);
    op(1'b1, 1'b0, 4'd5, '0, '0, 1'b1);
    idle(LAT + 2);
    chk("seg_merge", last_exp, {{30{8'hAA}}, 8'h55, 8'hAA});
    op(1'b1, 1'b1, 4'd5, rand_word(), '0, 1'b1);
    op(1'b1, 1'b0, 4'd5, '0, '0, 1'b1);
    idle(LAT + 2);
    chk("mask0_noop", last_exp, {{30{8'hAA}}, 8'h55, 8'hAA});

    // back-to-back reads
    for (int a = 1; a <= 3; a++) op(1'b1, 1'b1, ADDR_W'(a), rand_word(), '1, 1'b1);
    for (int a = 1; a <= 3; a++) op(1'b1, 1'b0, ADDR_W'(a), '0, '0, 1'b1);
    idle(LAT + 2);

    // random mix against the model
    for (int n = 0; n < 10000; n++) begin
      op($urandom_range(0, 9) != 0, 1'($urandom_range(0, 1)),
         ADDR_W'($urandom_range(0, DEPTH-1)), rand_word(),
         ($urandom_range(0, 3) == 0) ? '1 : MASK_W'($urandom), 1'b1);
    end
    idle(LAT + 2);

    // reset in the middle of a sweep restarts it from address 0
    @(posedge clock);
    #1;
    reset_n = 1'b0;
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    idle(7);
    #0 reset_n = 1'b0;
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    sweep_check("init_done_restart");
    read_all();

    chk("queue_empty", DATA_W'(exp_q.size()), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
